sram_1r1w_param: RTL and testbench
==================================

# sram_1r1w_param

Parametrised, synthesizable single-clock 1-read/1-write SRAM macro model, the next generation of the team's fixed 32x256 dual-port memory. Adds configurable width/depth, per-byte write mask, a configurable read pipeline with a valid strobe, a post-reset zero-initialisation sequencer and same-address collision reporting. Sits as the storage array under FIFO and buffer blocks that share one clock domain.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address width
- DEPTH, 1<<ADDR_WIDTH, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
- READ_LATENCY, 1, cycles from read request to dout1_valid; legal values 1 or 2
- MASK_WIDTH, DATA_WIDTH/8, derived, one bit per byte

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- csb0  input  1  active-low write select
- addr0  input  ADDR_WIDTH  write address
- din0  input  DATA_WIDTH  write data
- wmask0  input  MASK_WIDTH  byte enables, bit i covers din0[8i+7:8i]
- csb1  input  1  active-low read select
- addr1  input  ADDR_WIDTH  read address
- dout1  output  DATA_WIDTH  read data
- dout1_valid  output  1  dout1 carries a completed read
- ready  output  1  initialisation done; requests accepted only when high
- collision  output  1  one-cycle pulse: same-address read and write accepted in the same cycle

## Operation
- Reset values: dout1=0, dout1_valid=0, ready=0, collision=0; FSM in INIT, init address 0.
- FSM INIT: writes all-zero word to address init_addr each cycle, init_addr 0..DEPTH-1; ready=0; csb0/csb1 ignored. After writing DEPTH-1 -> READY.
- FSM READY: ready=1; stays until rst_n asserted. No other transitions.
- Write accepted when ready && !csb0: mem[addr0] byte i <= din0 byte i for each wmask0[i]=1; other bytes unchanged. wmask0=0 is a legal no-op (not an error).
- Read accepted when ready && !csb1: request enters read pipeline; data sampled from array in acceptance cycle.
- Out of range (addr >= DEPTH): write dropped; read completes with dout1=0 and dout1_valid=1.
- Same-address read+write in one accepted cycle: collision=1 next cycle; data per Configuration.
- dout1 holds last read data while dout1_valid=0; never driven X.
- Reset mid-operation: pipeline flushed, dout1_valid=0 immediately, memory re-zeroed by full INIT sequence.

## Timing
- Write accepted in cycle N visible to read accepted in cycle N+1.
- Read accepted in cycle N: dout1/dout1_valid registered, valid in cycle N+READ_LATENCY, for exactly one cycle per request.
- Back-to-back reads every cycle sustained; no backpressure.
- INIT lasts DEPTH cycles after rst_n deasserts; ready rises at the clock edge of cycle DEPTH (first cycle requests are honoured).
- collision asserts cycle N+1, independent of READ_LATENCY.

## Configuration
- SRAM_RDW_BYPASS_EN defined: same-address read+write returns merged data (new bytes where wmask0=1, stored bytes elsewhere).
- Undefined: same-address read returns pre-write (old) word.
- collision pulse is generated in both builds.

## Structure
- Shared package sram_pkg: FSM state enum (INIT, READY), READ_LATENCY legality check, byte-mask merge function used by write path and bypass.
- One sub-module: sram_rd_pipe, parametrised READ_LATENCY register chain carrying data and valid, async active-low reset, flush on reset.
- Array itself is a plain register array in the top module; no vendor macros.

## Test plan
- Reset, DEPTH=256: ready low for 256 cycles, then high; reads of 0x00, 0x80, 0xFF return 0x00000000 with dout1_valid at N+READ_LATENCY.
- Write 0xDEADBEEF to 0x10 wmask0=4'hF, then wmask0=4'b0101 din0=0x11223344: read 0x10 -> 0xDE22BE44.
- Same cycle write 0xCAFEF00D/read 0x20 (old 0x0): collision pulse next cycle; dout1=0xCAFEF00D with SRAM_RDW_BYPASS_EN, 0x00000000 without.
- READ_LATENCY=2, reads every cycle to addresses 0..7 pre-loaded with addr value: dout1 sequence 0..7 starting cycle N+2, dout1_valid continuously high 8 cycles.
- DEPTH=200: write to 0xF0 dropped; read 0xF0 -> 0x00000000, valid=1; INIT lasts 200 cycles.
- Assert rst_n during read burst: dout1_valid drops immediately, dout1=0, ready low, previously written 0xDEADBEEF reads back 0 after INIT.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the sram_1r1w_param storage macro.
//   - sram_state_e       : controller state (INIT zero-fill, READY)
//   - read_latency_legal : legality check for the READ_LATENCY parameter
//   - byte_merge         : byte-enable merge used by the write path and the
//                          read-during-write bypass
// byte_merge works on a fixed maximum width; callers cast in and out.
package sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  localparam int MAX_DW = 1024;
  localparam int MAX_MW = MAX_DW / 8;

  function automatic bit read_latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Bytes whose mask bit is set come from new_w, the rest from old_w.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_MW-1:0] mask
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_MW; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: read-data pipeline of LATENCY register stages carrying a
// valid bit alongside the data.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes all stages)
//   valid_i/data_i: read completion entering the pipe this cycle
//   valid_o/data_o: read completion leaving the pipe
// A stage's data register only loads when its incoming valid is high, so
// data_o holds the last completed read while valid_o is low.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [LATENCY-1:0]    valid_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/sram_1r1w_param.sv
// sram_1r1w_param: single-clock 1-read/1-write register-array memory with
// per-byte write mask, READ_LATENCY-stage read pipeline, post-reset zero
// fill and same-address collision pulse.
// Optional feature macro: SRAM_RDW_BYPASS_EN (same-address read during a
// write returns the merged new word instead of the old one).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   csb0/addr0/din0/wmask0 : write port (csb0 active-low)
//   csb1/addr1          : read port (csb1 active-low)
//   dout1/dout1_valid   : read result and its one-cycle strobe
//   ready               : zero fill finished, requests honoured
//   collision           : same-address read+write accepted last cycle
//   dbg_state_o         : controller state for observation
// Handshake: there is no backpressure. A request is taken on any rising
// edge where ready=1 and its csb is low; each accepted read produces exactly
// one cycle of dout1_valid=1 READ_LATENCY cycles later. Requests while
// ready=0 are ignored.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int ADDR_WIDTH   = 8,
  parameter  int DEPTH        = 1 << ADDR_WIDTH,
  parameter  int READ_LATENCY = 1,
  localparam int MASK_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [MASK_WIDTH-1:0] wmask0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  ready,
  output logic                  collision,
  output sram_state_e           dbg_state_o
);

  // An illegal latency falls back to a single stage.
  localparam int PIPE_LAT = read_latency_legal(READ_LATENCY) ? READ_LATENCY : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  sram_state_e           state_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  ready_q;
  logic                  collision_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_in_range, rd_in_range;
  logic                  wr_acc, rd_acc, collision_d;
  logic [DATA_WIDTH-1:0] rd_old, rd_data_d;

  assign wr_in_range = {1'b0, addr0} < DEPTH_W;
  assign rd_in_range = {1'b0, addr1} < DEPTH_W;
  // Out-of-range writes are dropped, so they never count as accepted.
  assign wr_acc      = ready_q && !csb0 && wr_in_range;
  assign rd_acc      = ready_q && !csb1;
  assign collision_d = wr_acc && rd_acc && (addr0 == addr1);

  always_comb begin
    rd_old    = rd_in_range ? mem_q[addr1] : '0;
    rd_data_d = rd_old;
`ifdef SRAM_RDW_BYPASS_EN
    if (collision_d) begin
      rd_data_d = DATA_WIDTH'(byte_merge(MAX_DW'(rd_old), MAX_DW'(din0),
                                         MAX_MW'(wmask0)));
    end
`endif
  end

  // Storage array: no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_addr_q] <= '0;
    end else if (wr_acc) begin
      mem_q[addr0] <= DATA_WIDTH'(byte_merge(MAX_DW'(mem_q[addr0]),
                                             MAX_DW'(din0), MAX_MW'(wmask0)));
    end
  end

  // Controller: zero-fill every word once after reset, then serve requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == LAST_ADDR) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (PIPE_LAT)
  ) u_rd_pipe (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(rd_acc),
    .data_i (rd_data_d),
    .valid_o(dout1_valid),
    .data_o (dout1)
  );

  assign ready       = ready_q;
  assign collision   = collision_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Bench for sram_1r1w_param. Two instances share one stimulus stream:
// A = defaults (DEPTH 256, latency 1), B = DEPTH 200, latency 2.
// Each has its own array-based reference model and expected queue.
module tb_sram_1r1w_param;
  import sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        csb0 = 1'b1, csb1 = 1'b1;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;
  logic [3:0]  wmask0 = '0;

  logic [31:0] dout_a, dout_b;
  logic        val_a, val_b, rdy_a, rdy_b, col_a, col_b;
  sram_state_e st_a, st_b;

  sram_1r1w_param u_dut_a (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .addr0(addr0), .din0(din0),
    .wmask0(wmask0), .csb1(csb1), .addr1(addr1), .dout1(dout_a),
    .dout1_valid(val_a), .ready(rdy_a), .collision(col_a), .dbg_state_o(st_a)
  );

  sram_1r1w_param #(.DEPTH(200), .READ_LATENCY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .csb0(csb0), .addr0(addr0), .din0(din0),
    .wmask0(wmask0), .csb1(csb1), .addr1(addr1), .dout1(dout_b),
    .dout1_valid(val_b), .ready(rdy_b), .collision(col_b), .dbg_state_o(st_b)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;   // rising edges since rst_n released
  int depth_m [2] = '{256, 200};
  int lat_m   [2] = '{1, 2};
  logic [31:0] mem_m [2][256];
  logic [31:0] exp_q0[$], exp_q1[$];
  int          due_q0[$], due_q1[$];
  logic [31:0] last_m [2];
  logic        coll_m [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge_m(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
    for (int i = 0; i < 2; i++) begin
      last_m[i] = '0;
      coll_m[i] = 1'b0;
      for (int a = 0; a < 256; a++) mem_m[i][a] = '0;
    end
    cyc = 0;
  endtask

  // Apply the currently driven request to each model as of the coming edge.
  task automatic model_edge();
    logic rd, wr;
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      coll_m[i] = 1'b0;
      if (cyc >= depth_m[i]) begin
        rd = !csb1;
        wr = !csb0 && (int'(addr0) < depth_m[i]);
        if (rd) begin
          v = (int'(addr1) < depth_m[i]) ? mem_m[i][addr1] : 32'h0;
          if (wr && addr0 == addr1) begin
            coll_m[i] = 1'b1;
`ifdef SRAM_RDW_BYPASS_EN
            v = merge_m(v, din0, wmask0);
`endif
          end
          if (i == 0) begin exp_q0.push_back(v); due_q0.push_back(cyc + lat_m[i]); end
          else        begin exp_q1.push_back(v); due_q1.push_back(cyc + lat_m[i]); end
        end
        if (wr) mem_m[i][addr0] = merge_m(mem_m[i][addr0], din0, wmask0);
      end
    end
  endtask

  task automatic check_outputs();
    logic        has;
    logic [31:0] d, g_dout;
    logic        g_val, g_rdy, g_col;
    sram_state_e g_st;
    string       p;
    for (int i = 0; i < 2; i++) begin
      has = 1'b0;
      d   = '0;
      if (i == 0) begin
        p = "A"; g_dout = dout_a; g_val = val_a; g_rdy = rdy_a; g_col = col_a; g_st = st_a;
        if (due_q0.size() > 0 && due_q0[0] == cyc) begin
          has = 1'b1; d = exp_q0.pop_front(); void'(due_q0.pop_front());
        end
      end else begin
        p = "B"; g_dout = dout_b; g_val = val_b; g_rdy = rdy_b; g_col = col_b; g_st = st_b;
        if (due_q1.size() > 0 && due_q1[0] == cyc) begin
          has = 1'b1; d = exp_q1.pop_front(); void'(due_q1.pop_front());
        end
      end
      if (has) last_m[i] = d;
      check({p, ".dout1_valid"}, 32'(g_val), 32'(has));
      check({p, ".dout1"}, g_dout, last_m[i]);
      check({p, ".ready"}, 32'(g_rdy), 32'(cyc >= depth_m[i]));
      check({p, ".collision"}, 32'(g_col), 32'(coll_m[i]));
      check({p, ".state_ready"}, 32'(g_st == ST_READY), 32'(cyc >= depth_m[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic req(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic [3:0] wm, input logic re, input logic [7:0] ra);
    csb0 = !we; addr0 = wa; din0 = wd; wmask0 = wm;
    csb1 = !re; addr1 = ra;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) req(1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 8'h0);
  endtask

  task automatic wait_ready();
    while (cyc < 256) idle(1);
  endtask

  // Assert reset asynchronously mid-cycle and check the outputs clear at once.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("A.rst_valid", 32'(val_a), 32'h0);
    check("A.rst_dout", dout_a, 32'h0);
    check("A.rst_ready", 32'(rdy_a), 32'h0);
    check("B.rst_valid", 32'(val_b), 32'h0);
    check("B.rst_dout", dout_b, 32'h0);
    check("B.rst_ready", 32'(rdy_b), 32'h0);
    csb0 = 1'b1; csb1 = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic       r_we, r_re;
  logic [7:0] r_wa, r_ra;

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    check("A.reset_valid", 32'(val_a), 32'h0);
    check("A.reset_dout", dout_a, 32'h0);
    check("A.reset_ready", 32'(rdy_a), 32'h0);
    check("A.reset_collision", 32'(col_a), 32'h0);
    check("B.reset_ready", 32'(rdy_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-fill timing is checked on every cycle while waiting
    wait_ready();

    // fresh memory reads zero; 0xFF is out of range for B
    req(0, 8'h00, 0, 0, 1, 8'h00);
    req(0, 8'h00, 0, 0, 1, 8'h80);
    req(0, 8'h00, 0, 0, 1, 8'hFF);
    idle(3);

    // byte mask merge -> 0xDE22BE44
    req(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 8'h00);
    req(1, 8'h10, 32'h11223344, 4'b0101, 0, 8'h00);
    req(0, 8'h00, 0, 0, 1, 8'h10);
    idle(3);

    // same-address read during write
    req(1, 8'h20, 32'hCAFEF00D, 4'hF, 1, 8'h20);
    req(0, 8'h00, 0, 0, 1, 8'h20);
    idle(3);

    // preload 0..7, then back-to-back reads
    for (int a = 0; a < 8; a++) req(1, 8'(a), 32'(a), 4'hF, 0, 8'h00);
    for (int a = 0; a < 8; a++) req(0, 8'h00, 0, 0, 1, 8'(a));
    idle(3);

    // 0xF0: stored in A, dropped in B
    req(1, 8'hF0, 32'h12345678, 4'hF, 0, 8'h00);
    req(0, 8'h00, 0, 0, 1, 8'hF0);
    idle(3);

    // empty mask is a no-op
    req(1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 8'h00);
    req(0, 8'h00, 0, 0, 1, 8'h10);
    idle(3);

    // randomized traffic, biased toward a few hot addresses
    for (int k = 0; k < 400; k++) begin
      r_we = 1'($urandom_range(0, 1));
      r_re = 1'($urandom_range(0, 1));
      r_wa = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      r_ra = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      if (r_wa == r_ra && r_wa >= 8'd200) r_ra = r_wa - 8'd100;
      req(r_we, r_wa, 32'($urandom), 4'($urandom_range(0, 15)), r_re, r_ra);
    end
    idle(3);

    // reset in the middle of a read burst, then memory must be zero again
    req(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 8'h00);
    for (int k = 0; k < 5; k++) req(0, 8'h00, 0, 0, 1, 8'h10);
    async_reset();
    wait_ready();
    req(0, 8'h00, 0, 0, 1, 8'h10);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
